// File: rtl/pll_strobe_pkg.sv
// Shared types and width helpers for the lock-qualified strobe generator.
package pll_strobe_pkg;

    typedef enum logic [1:0] {
        StWait   = 2'd0,
        StSettle = 2'd1,
        StRun    = 2'd2,
        StApply  = 2'd3
    } state_e;

    // Channel datapath width; DIV_W fields are zero-extended into it.
    localparam int MaxDivW = 16;

    typedef struct packed {
        logic [MaxDivW-1:0] div;
        logic [MaxDivW-1:0] phase;
    } chan_cfg_t;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Settle counter runs from 1 up to LOCK_CYCLES+1.
    function automatic int lock_cnt_w(input int lock_cycles);
        return $clog2(lock_cycles + 2);
    endfunction

endpackage

// File: rtl/pll_strobe_chan.sv
// One strobe channel: clamped div/phase registers, period counter and registered strobe.
module pll_strobe_chan
    import pll_strobe_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      load_i,
    input  chan_cfg_t cfg_i,
    input  logic      restart_i,
    input  logic      run_en_i,
    output logic      strobe_o
);

    chan_cfg_t          cfg_q, cfg_d;
    logic [MaxDivW-1:0] cnt_q, cnt_d, cnt_inc;
    logic               strobe_q, strobe_d;

    always_comb begin
        cfg_d = cfg_q;
        if (load_i) begin
            cfg_d.div = cfg_i.div;
            if (cfg_i.div == '0) begin
                cfg_d.phase = '0;
            end else if (cfg_i.phase >= cfg_i.div) begin
                cfg_d.phase = cfg_i.div - MaxDivW'(1);
            end else begin
                cfg_d.phase = cfg_i.phase;
            end
        end

        // cnt tracks n mod div for the upcoming cycle so the strobe can be registered.
        cnt_inc = cnt_q + MaxDivW'(1);
        cnt_d   = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (run_en_i) begin
            cnt_d = (cnt_inc >= cfg_d.div) ? '0 : cnt_inc;
        end

        strobe_d = run_en_i && (cfg_d.div != '0) && (cnt_d == cfg_d.phase);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q    <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/pll_strobe_gen.sv
// Lock debounce FSM, lock-loss counter and NUM_CH phase-aligned strobe channels.
module pll_strobe_gen
    import pll_strobe_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 256
) (
    input  logic                        refclk,
    input  logic                        rst,
    input  logic                        pll_locked_in,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [DIV_W-1:0]            cfg_phase,
    output logic [NUM_CH-1:0]           strobe,
    output logic                        locked,
    output logic [7:0]                  lock_loss_cnt
);

    localparam int                  ChW       = ch_idx_w(NUM_CH);
    localparam int                  SettleW   = lock_cnt_w(LOCK_CYCLES);
    localparam logic [SettleW-1:0]  SettleEnd = SettleW'(LOCK_CYCLES + 1);

    state_e             state_q, state_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [7:0]         loss_q, loss_d;
    logic               locked_q;
    logic               wr, wr_ch, run_en, restart;
    chan_cfg_t          wr_cfg;

    assign cfg_ready = !rst && (state_q != StApply);
    assign wr        = cfg_valid && cfg_ready;
    assign wr_ch     = wr && (int'(cfg_ch) < NUM_CH);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        loss_d   = loss_q;
        unique case (state_q)
            StWait: begin
                if (pll_locked_in) begin
                    state_d  = StSettle;
                    settle_d = SettleW'(1);
                end
            end
            StSettle: begin
                if (!pll_locked_in) begin
                    state_d  = StWait;
                    settle_d = '0;
                end else if (settle_q == SettleEnd) begin
                    state_d  = StRun;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SettleW'(1);
                end
            end
            StRun, StApply: begin
                if (!pll_locked_in) begin
                    state_d = StWait;
                    if (loss_q != 8'hff) begin
                        loss_d = loss_q + 8'd1;
                    end
                end else if (state_q == StApply) begin
                    state_d = StRun;
                end else if (wr_ch) begin
                    state_d = StApply;
                end
            end
            default: state_d = StWait;
        endcase
    end

    // Every entry into RUN restarts all channel counters together.
    assign run_en  = (state_d == StRun);
    assign restart = run_en && (state_q != StRun);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= StWait;
            settle_q <= '0;
            loss_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            loss_q   <= loss_d;
            locked_q <= (state_d == StRun) || (state_d == StApply);
        end
    end

    assign wr_cfg.div   = MaxDivW'(cfg_div);
    assign wr_cfg.phase = MaxDivW'(cfg_phase);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        pll_strobe_chan u_chan (
            .clk_i     (refclk),
            .rst_i     (rst),
            .load_i    (wr_ch && (cfg_ch == ChW'(i))),
            .cfg_i     (wr_cfg),
            .restart_i (restart),
            .run_en_i  (run_en),
            .strobe_o  (strobe[i])
        );
    end

    assign locked        = locked_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_strobe_gen.sv
// Directed plus randomized bench for pll_strobe_gen against a cycle-level behavioural model.
module tb_pll_strobe_gen;

    localparam int NumCh      = 6;
    localparam int DivW       = 8;
    localparam int LockCycles = 16;
    localparam int ChW        = 3;

    logic             refclk = 1'b0;
    logic             rst;
    logic             pll;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ChW-1:0]   cfg_ch;
    logic [DivW-1:0]  cfg_div;
    logic [DivW-1:0]  cfg_phase;
    logic [NumCh-1:0] strobe;
    logic             locked;
    logic [7:0]       lock_loss_cnt;

    int checks   = 0;
    int failures = 0;

    // Model: locked after LockCycles+2 consecutive high samples; n counts RUN cycles.
    int m_div[NumCh];
    int m_phase[NumCh];
    bit m_locked;
    bit m_apply;
    int m_n;
    int m_hi;
    int m_loss;

    always #5 refclk = ~refclk;

    pll_strobe_gen #(
        .NUM_CH      (NumCh),
        .DIV_W       (DivW),
        .LOCK_CYCLES (LockCycles)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked_in (pll),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_ch        (cfg_ch),
        .cfg_div       (cfg_div),
        .cfg_phase     (cfg_phase),
        .strobe        (strobe),
        .locked        (locked),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ok;
        int c, d, p;
        if (rst) begin
            for (int i = 0; i < NumCh; i++) begin
                m_div[i]   = 0;
                m_phase[i] = 0;
            end
            m_locked = 0;
            m_apply  = 0;
            m_n      = 0;
            m_hi     = 0;
            m_loss   = 0;
            return;
        end
        c  = int'(cfg_ch);
        d  = int'(cfg_div);
        p  = int'(cfg_phase);
        ok = cfg_valid && !m_apply && (c < NumCh);
        if (ok) begin
            m_div[c]   = d;
            m_phase[c] = (d == 0) ? 0 : ((p > d - 1) ? d - 1 : p);
        end
        if (!pll) begin
            if (m_locked && m_loss < 255) m_loss++;
            m_locked = 0;
            m_apply  = 0;
            m_hi     = 0;
        end else if (!m_locked) begin
            m_hi++;
            if (m_hi == LockCycles + 2) begin
                m_locked = 1;
                m_n      = 0;
            end
        end else if (m_apply) begin
            m_apply = 0;
            m_n     = 0;
        end else if (ok) begin
            m_apply = 1;
        end else begin
            m_n++;
        end
    endtask

    function automatic logic [NumCh-1:0] exp_strobe();
        logic [NumCh-1:0] e;
        for (int i = 0; i < NumCh; i++) begin
            e[i] = m_locked && !m_apply && (m_div[i] != 0) && ((m_n % m_div[i]) == m_phase[i]);
        end
        return e;
    endfunction

    task automatic tick(input logic p, input logic v, input int ch, input int div, input int ph);
        pll       = p;
        cfg_valid = v;
        cfg_ch    = ChW'(ch);
        cfg_div   = DivW'(div);
        cfg_phase = DivW'(ph);
        @(posedge refclk);
        model_step();
        #1;
        check("strobe", 32'(strobe), 32'(exp_strobe()));
        check("locked", 32'(locked), 32'(m_locked));
        check("cfg_ready", 32'(cfg_ready), 32'(!rst && !m_apply));
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
    endtask

    task automatic idle(input int n, input logic p);
        for (int i = 0; i < n; i++) tick(p, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int first;
        rst = 1'b1;
        pll = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch = '0;
        cfg_div = '0;
        cfg_phase = '0;

        tick(1'b0, 1'b0, 0, 0, 0);
        tick(1'b1, 1'b1, 0, 4, 1);
        rst = 1'b0;

        // Config in WAIT, then a one-cycle glitch during SETTLE.
        tick(1'b0, 1'b1, 0, 4, 1);
        idle(10, 1'b1);
        tick(1'b0, 1'b0, 0, 0, 0);
        first = -1;
        for (int e = 0; e < 40; e++) begin
            tick(1'b1, 1'b0, 0, 0, 0);
            if (locked === 1'b1 && first < 0) first = e;
        end
        check("lock_latency", 32'(first), 32'(LockCycles + 1));
        check("glitch_loss", 32'(lock_loss_cnt), 32'd0);

        // Runtime reconfig with phase clamp, then edge-value channels.
        tick(1'b1, 1'b1, 1, 3, 5);
        check("apply_ready", 32'(cfg_ready), 32'd0);
        idle(20, 1'b1);
        tick(1'b1, 1'b1, 2, 0, 7);
        tick(1'b1, 1'b1, 3, 1, 0);
        tick(1'b1, 1'b1, 3, 1, 0);
        idle(12, 1'b1);

        // Out-of-range channel index.
        tick(1'b1, 1'b1, 7, 5, 2);
        check("bad_ch_ready", 32'(cfg_ready), 32'd1);
        idle(10, 1'b1);

        // Lock loss in RUN, then relock with retained config.
        tick(1'b0, 1'b0, 0, 0, 0);
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_cnt", 32'(lock_loss_cnt), 32'd1);
        idle(40, 1'b1);

        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 15)));
        end

        // Reset mid-RUN.
        idle(25, 1'b1);
        rst = 1'b1;
        tick(1'b1, 1'b1, 0, 5, 0);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        idle(30, 1'b1);

        // Saturation of the lock-loss counter.
        for (int k = 0; k < 258; k++) begin
            idle(LockCycles + 3, 1'b1);
            tick(1'b0, 1'b0, 0, 0, 0);
        end
        check("loss_sat", 32'(lock_loss_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
